multi_edge_det: RTL and testbench

MULTI_EDGE_DET -- requirements
Module: multi_edge_det

---
 rtl/multi_edge_det.sv | 116 +++++++++++
 tb/tb_multi_edge_det.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_det.sv
// Multi-channel synchronised edge detector with sticky, mode-selected events.
// Define EDGE_DET_FILTER_EN to build the per-channel glitch filter.
module multi_edge_det #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     signal,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     event_clr,
  output logic [CHANNELS-1:0]     level,
  output logic [CHANNELS-1:0]     pos_edge,
  output logic [CHANNELS-1:0]     neg_edge,
  output logic [CHANNELS-1:0]     event_pending,
  output logic                    irq
);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pos_q, pos_d;
  logic [CHANNELS-1:0] neg_q, neg_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] rise_sel, fall_sel;

  always_comb begin
    sync_d[0] = signal;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef EDGE_DET_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; accept on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_filter_cycles = FILTER_CYCLES;

  always_comb begin
    level_d = sync;
  end
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      rise_sel[i] = mode[2*i];
      fall_sel[i] = mode[2*i+1];
    end
  end

  // Set wins over clear so an event coinciding with event_clr is kept.
  always_comb begin
    pos_d  = level_d & ~level_q;
    neg_d  = ~level_d & level_q;
    pend_d = (pos_d & rise_sel) | (neg_d & fall_sel)
           | (pend_q & ~event_clr);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      pend_q  <= '0;
    end else begin
      level_q <= level_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      pend_q  <= pend_d;
    end
  end

  assign level         = level_q;
  assign pos_edge      = pos_q;
  assign neg_edge      = neg_q;
  assign event_pending = pend_q;
  assign irq           = |pend_q;

endmodule

// File: tb/tb_multi_edge_det.sv
// Directed bench for multi_edge_det; expected events are queued when
// stimulus is driven and retired on the cycle the DUT must show them.
module tb_multi_edge_det;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FC = 4;
`ifdef EDGE_DET_FILTER_EN
  localparam int FLT = FC;
`else
  localparam int FLT = 1;
`endif
  localparam int LAT = SS + FLT;

  localparam int K_CLR  = 0;
  localparam int K_RISE = 1;
  localparam int K_FALL = 2;

  logic            clk_sys;
  logic            reset;
  logic [CH-1:0]   signal;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   event_clr;
  logic [CH-1:0]   level;
  logic [CH-1:0]   pos_edge;
  logic [CH-1:0]   neg_edge;
  logic [CH-1:0]   event_pending;
  logic            irq;

  multi_edge_det #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SS),
    .FILTER_CYCLES(FC)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .signal       (signal),
    .mode         (mode),
    .event_clr    (event_clr),
    .level        (level),
    .pos_edge     (pos_edge),
    .neg_edge     (neg_edge),
    .event_pending(event_pending),
    .irq          (irq)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t sb[$];
  int  cyc;
  int  n_cmp;
  int  n_err;

  logic [CH-1:0] e_level, e_pos, e_neg, e_pend;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(e_level));
    chk("pos_edge", 32'(pos_edge), 32'(e_pos));
    chk("neg_edge", 32'(neg_edge), 32'(e_neg));
    chk("event_pending", 32'(event_pending), 32'(e_pend));
    chk("irq", 32'(irq), 32'(|e_pend));
  endtask

  // Retire due events: clears first so a same-cycle set wins.
  task automatic apply();
    ev_t keep[$];
    e_pos = '0;
    e_neg = '0;
    for (int k = K_CLR; k <= K_FALL; k++) begin
      foreach (sb[j]) begin
        if (sb[j].cyc == cyc && sb[j].kind == k) begin
          case (k)
            K_CLR: e_pend[sb[j].ch] = 1'b0;
            K_RISE: begin
              e_level[sb[j].ch] = 1'b1;
              e_pos[sb[j].ch]   = 1'b1;
              if (mode[2*sb[j].ch]) e_pend[sb[j].ch] = 1'b1;
            end
            default: begin
              e_level[sb[j].ch] = 1'b0;
              e_neg[sb[j].ch]   = 1'b1;
              if (mode[2*sb[j].ch+1]) e_pend[sb[j].ch] = 1'b1;
            end
          endcase
        end
      end
    end
    foreach (sb[j]) begin
      if (sb[j].cyc > cyc) keep.push_back(sb[j]);
    end
    sb = keep;
  endtask

  task automatic step();
    @(posedge clk_sys);
    cyc++;
    @(negedge clk_sys);
    apply();
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drive(input int ch, input logic v, input bit passes);
    ev_t e;
    if (signal[ch] != v && passes) begin
      e.cyc  = cyc + LAT;
      e.ch   = ch;
      e.kind = v ? K_RISE : K_FALL;
      sb.push_back(e);
    end
    signal[ch] = v;
  endtask

  task automatic glitch(input int ch, input int g);
    bit ok;
    ok = (g >= FLT);
    drive(ch, 1'b1, ok);
    run(g);
    drive(ch, 1'b0, ok);
  endtask

  task automatic pulse_clr(input logic [CH-1:0] m);
    ev_t e;
    for (int i = 0; i < CH; i++) begin
      if (m[i]) begin
        e.cyc  = cyc + 1;
        e.ch   = i;
        e.kind = K_CLR;
        sb.push_back(e);
      end
    end
    event_clr = m;
    step();
    event_clr = '0;
  endtask

  // Asynchronous reset: outputs must drop before any clock edge.
  task automatic do_reset(input int n);
    ev_t e;
    reset = 1'b1;
    #1;
    sb.delete();
    e_level = '0;
    e_pos   = '0;
    e_neg   = '0;
    e_pend  = '0;
    check_all();
    run(n);
    reset = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (signal[i]) begin
        e.cyc  = cyc + LAT;
        e.ch   = i;
        e.kind = K_RISE;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    signal    = '0;
    mode      = '0;
    event_clr = '0;
    e_level   = '0;
    e_pos     = '0;
    e_neg     = '0;
    e_pend    = '0;
    do_reset(3);

    // ch3 none, ch2 fall, ch1 rise, ch0 both
    mode = 8'b00_10_01_11;

    drive(0, 1'b1, 1'b1);
    run(LAT + 4);

    glitch(1, FC - 1);
    run(LAT + 4);
    glitch(1, FC);
    run(LAT + 4);

    drive(2, 1'b1, 1'b1);
    run(LAT + 4);
    drive(2, 1'b0, 1'b1);
    run(LAT + 4);

    drive(0, 1'b0, 1'b1);
    run(LAT + 4);
    pulse_clr(4'b0011);
    run(2);

    drive(2, 1'b1, 1'b1);
    run(LAT + 4);
    drive(2, 1'b0, 1'b1);
    run(LAT - 1);
    pulse_clr(4'b0100);
    pulse_clr(4'b0100);
    run(3);

    drive(3, 1'b1, 1'b1);
    run(LAT + 4);
    drive(0, 1'b1, 1'b1);
    run(LAT + 2);
    mode[1:0] = 2'b00;
    run(3);

    drive(1, 1'b1, 1'b1);
    run(2);
    do_reset(2);
    run(LAT + 5);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
